// File: rtl/anpc_gate_deadtime.sv
// 3L-ANPC gate sequencer: break-before-make with programmable dead time.
// Optional `GATE_INTERLOCK_EN adds a shoot-through check on the next gate word.
module anpc_gate_deadtime #(
  parameter int TDELAY_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [2:0]              state_i,
  input  logic [TDELAY_WIDTH-1:0] tdelay_i,
  output logic [5:0]              gate_o,
  output logic [2:0]              applied_state_o,
  output logic                    applied_vld_o,
  output logic                    busy_o,
  output logic                    fault_o
);

  typedef enum logic [1:0] {OFF_ALL, IDLE, DEAD, ON} fsm_t;

  localparam logic [2:0] ST_P = 3'd0;

  // Gate word is {S6,S5,S4,S3,S2,S1}
  function automatic logic [5:0] gate_map(input logic [2:0] s);
    case (s)
      3'd0:    gate_map = 6'b100011;
      3'd1:    gate_map = 6'b011010;
      3'd2:    gate_map = 6'b010010;
      3'd3:    gate_map = 6'b100100;
      3'd4:    gate_map = 6'b100101;
      3'd5:    gate_map = 6'b011100;
      default: gate_map = 6'b000000;
    endcase
  endfunction

  fsm_t                    fsm_q, fsm_d;
  logic [2:0]              tgt_q, tgt_d;
  logic [TDELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [5:0]              gate_d;
  logic [2:0]              app_d;
  logic                    vld_d, busy_d, fault_d;
  logic                    violation;
  logic                    locked;
  logic                    st_valid, st_change;
  logic [2:0]              tgt_sel;
  logic [5:0]              tgt_map;
  logic [5:0]              off_mask;

  assign st_valid  = (state_i <= 3'd5);
  assign st_change = (state_i != applied_state_o);
  // While dead-timing, the latched target drives the map; otherwise the live request.
  assign tgt_sel   = (fsm_q == DEAD) ? tgt_q : state_i;
  assign tgt_map   = gate_map(tgt_sel);
  assign off_mask  = gate_o & ~tgt_map;

`ifdef GATE_INTERLOCK_EN
  logic lock_q, lock_d;
  assign locked = lock_q;

  function automatic logic ilk_bad(input logic [5:0] g);
    ilk_bad = (g[0] & g[4]) | (g[3] & g[5]) | (&g[3:0]);
  endfunction
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q           <= OFF_ALL;
      tgt_q           <= ST_P;
      cnt_q           <= '0;
      gate_o          <= '0;
      applied_state_o <= ST_P;
      applied_vld_o   <= 1'b0;
      busy_o          <= 1'b0;
      fault_o         <= 1'b0;
    end else begin
      fsm_q           <= fsm_d;
      tgt_q           <= tgt_d;
      cnt_q           <= cnt_d;
      gate_o          <= gate_d;
      applied_state_o <= app_d;
      applied_vld_o   <= vld_d;
      busy_o          <= busy_d;
      fault_o         <= fault_d;
    end
  end

`ifdef GATE_INTERLOCK_EN
  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`endif

  always_comb begin
    fsm_d = fsm_q;
    if (!en_i) begin
      fsm_d = OFF_ALL;
    end else begin
      case (fsm_q)
        OFF_ALL: if (st_valid && !locked) fsm_d = ON;
        IDLE:    if (st_valid && st_change) fsm_d = (off_mask != '0) ? DEAD : ON;
        DEAD:    if (cnt_q == TDELAY_WIDTH'(1)) fsm_d = ON;
        ON:      fsm_d = IDLE;
        default: fsm_d = OFF_ALL;
      endcase
      if (violation) fsm_d = OFF_ALL;
    end
  end

  always_comb begin
    gate_d    = gate_o;
    app_d     = applied_state_o;
    vld_d     = applied_vld_o;
    busy_d    = busy_o;
    fault_d   = fault_o;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    violation = 1'b0;
`ifdef GATE_INTERLOCK_EN
    lock_d    = lock_q;
`endif
    if (!en_i) begin
      // Forced turn-off skips dead time; disabling also clears fault and lockout.
      gate_d  = '0;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      fault_d = 1'b0;
`ifdef GATE_INTERLOCK_EN
      lock_d  = 1'b0;
`endif
    end else begin
      case (fsm_q)
        OFF_ALL: begin
          if (!st_valid) begin
            fault_d = 1'b1;
          end else if (!locked) begin
            tgt_d  = state_i;
            gate_d = tgt_map;
            app_d  = state_i;
            vld_d  = 1'b1;
          end
        end
        IDLE: begin
          if (!st_valid) begin
            fault_d = 1'b1;
          end else if (st_change) begin
            tgt_d = state_i;
            if (off_mask != '0) begin
              gate_d = gate_o & tgt_map;
              busy_d = 1'b1;
              cnt_d  = (tdelay_i == '0) ? TDELAY_WIDTH'(1) : tdelay_i;
            end else begin
              gate_d = tgt_map;
              app_d  = state_i;
              vld_d  = 1'b1;
            end
          end
        end
        DEAD: begin
          if (cnt_q == TDELAY_WIDTH'(1)) begin
            gate_d = tgt_map;
            app_d  = tgt_q;
            vld_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q - TDELAY_WIDTH'(1);
          end
        end
        default: ;
      endcase
`ifdef GATE_INTERLOCK_EN
      violation = ilk_bad(gate_d);
      if (violation) begin
        gate_d  = '0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b1;
        lock_d  = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_anpc_gate_deadtime.sv
// Directed bench for anpc_gate_deadtime: dead-time sequencing, masking, faults, enable.
module tb_anpc_gate_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic [2:0] state_i;
  logic [7:0] tdelay_i;
  logic [5:0] gate_o;
  logic [2:0] applied_state_o;
  logic       applied_vld_o, busy_o, fault_o;

  int checks   = 0;
  int failures = 0;

  anpc_gate_deadtime #(.TDELAY_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .state_i(state_i), .tdelay_i(tdelay_i),
    .gate_o(gate_o), .applied_state_o(applied_state_o), .applied_vld_o(applied_vld_o),
    .busy_o(busy_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] g, input logic b);
    chk({tag, ".gate"}, {2'b0, gate_o}, {2'b0, g});
    chk({tag, ".busy"}, {7'b0, busy_o}, {7'b0, b});
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; state_i = 3'd0; tdelay_i = 8'd5;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst.gate",  {2'b0, gate_o}, 8'h00);
    chk("rst.app",   {5'b0, applied_state_o}, 8'h00);
    chk("rst.vld",   {7'b0, applied_vld_o}, 8'h00);
    chk("rst.busy",  {7'b0, busy_o}, 8'h00);
    chk("rst.fault", {7'b0, fault_o}, 8'h00);

    // Enable from all-off: P one cycle later, no dead time
    en_i = 1'b1; state_i = 3'd0;
    tick();
    chk_out("en_p", 6'b100011, 1'b0);
    chk("en_p.vld", {7'b0, applied_vld_o}, 8'h01);
    tick();
    chk_out("en_p_idle", 6'b100011, 1'b0);

    // P -> Z_U1 with D=5
    tdelay_i = 8'd5; state_i = 3'd2;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_out($sformatf("p_zu1.dead%0d", i), 6'b000010, 1'b1);
    end
    tick();
    chk_out("p_zu1.on", 6'b010010, 1'b0);
    chk("p_zu1.app", {5'b0, applied_state_o}, 8'd2);
    tick();

    // Z_U1 -> Z_U2: nothing turns off, direct
    state_i = 3'd1;
    tick();
    chk_out("zu1_zu2", 6'b011010, 1'b0);
    chk("zu1_zu2.app", {5'b0, applied_state_o}, 8'd1);
    tick();

    // Z_U2 -> Z_U1 with tdelay 0 -> D=1
    tdelay_i = 8'd0; state_i = 3'd2;
    tick();
    chk_out("zu2_zu1.dead", 6'b010010, 1'b1);
    tick();
    chk_out("zu2_zu1.on", 6'b010010, 1'b0);
    chk("zu2_zu1.app", {5'b0, applied_state_o}, 8'd2);
    tick();

    // Back to P with D=1
    state_i = 3'd0;
    tick();
    chk_out("zu1_p.dead", 6'b000010, 1'b1);
    tick();
    chk_out("zu1_p.on", 6'b100011, 1'b0);
    tick();

    // P -> N with D=10; request moves to Z_L1 mid-dead and is held off
    tdelay_i = 8'd10; state_i = 3'd5;
    tick();
    chk_out("p_n.dead1", 6'b000000, 1'b1);
    state_i = 3'd3;
    for (int i = 2; i <= 10; i++) begin
      tick();
      chk_out($sformatf("p_n.dead%0d", i), 6'b000000, 1'b1);
    end
    tick();
    chk_out("p_n.on", 6'b011100, 1'b0);
    chk("p_n.app", {5'b0, applied_state_o}, 8'd5);
    tick();
    chk_out("p_n.idle", 6'b011100, 1'b0);
    tick();
    chk_out("n_zl1.dead1", 6'b000100, 1'b1);
    tdelay_i = 8'd2; // ignored while dead-timing
    for (int i = 2; i <= 10; i++) begin
      tick();
      chk_out($sformatf("n_zl1.dead%0d", i), 6'b000100, 1'b1);
    end
    tick();
    chk_out("n_zl1.on", 6'b100100, 1'b0);
    chk("n_zl1.app", {5'b0, applied_state_o}, 8'd3);
    tick();

    // Invalid code: gates held, sticky fault; disable clears everything
    state_i = 3'd7;
    tick();
    chk_out("inv", 6'b100100, 1'b0);
    chk("inv.fault", {7'b0, fault_o}, 8'h01);
    tick();
    chk("inv.fault_hold", {7'b0, fault_o}, 8'h01);
    en_i = 1'b0;
    tick();
    chk_out("dis", 6'b000000, 1'b0);
    chk("dis.fault", {7'b0, fault_o}, 8'h00);
    chk("dis.vld", {7'b0, applied_vld_o}, 8'h00);

    // Disable mid-dead: immediate all-off
    en_i = 1'b1; state_i = 3'd0;
    tick();
    chk_out("re_en", 6'b100011, 1'b0);
    tick();
    tdelay_i = 8'd5; state_i = 3'd2;
    tick();
    chk_out("abort.dead", 6'b000010, 1'b1);
    en_i = 1'b0;
    tick();
    chk_out("abort.off", 6'b000000, 1'b0);

    // Maximum dead time 255 must not wrap
    en_i = 1'b1; state_i = 3'd0;
    tick(); tick();
    tdelay_i = 8'd255; state_i = 3'd2;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 1 || i == 254 || i == 255)
        chk_out($sformatf("dmax.dead%0d", i), 6'b000010, 1'b1);
    end
    tick();
    chk_out("dmax.on", 6'b010010, 1'b0);
    tick();

`ifdef GATE_INTERLOCK_EN
    // S1&S5 pattern forced into the map while leaving all-off
    en_i = 1'b0; state_i = 3'd0;
    tick();
    force dut.tgt_map = 6'b010001;
    en_i = 1'b1;
    tick();
    chk_out("ilk.trip", 6'b000000, 1'b0);
    chk("ilk.fault", {7'b0, fault_o}, 8'h01);
    release dut.tgt_map;
    tick(); tick();
    chk_out("ilk.locked", 6'b000000, 1'b0);
    chk("ilk.fault_hold", {7'b0, fault_o}, 8'h01);
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    chk_out("ilk.recover", 6'b100011, 1'b0);
    chk("ilk.fault_clr", {7'b0, fault_o}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
